// File: rtl/portgroup_txn.sv
// -----------------------------------------------------------------------------
// portgroup_txn
//   Core-side port-group transmitter. A start strobe snapshots the channel mask
//   and all channel words. The enabled channels are then sent, lowest channel
//   first, as one frame over a valid/ready stream. An optional idle gap can be
//   inserted between the words of a frame. Busy, done and a completed-frame
//   count are reported back to the register file.
//
// Parameters
//   width_p  data word width (>=1)
//   chcnt_p  number of TX channels (>=1)
//   gap_p    idle cycles between consecutive words of a frame (0..255)
//
// Ports
//   main_clk_i               clock
//   main_rst_an_i            synchronous reset, active-low
//   regf_ctrl_ena_rval_i     global transmit enable
//   regf_ctrl_chmask_rval_i  channel enable mask
//   regf_tx_data_rval_i      channel i word at bits [i*width_p +: width_p]
//   regf_tx_start_wr_i       single-cycle start strobe
//   regf_tx_busy_o           frame in progress
//   regf_tx_done_o           one-cycle pulse when a frame completes
//   regf_tx_cnt_o            completed-frame counter (wraps)
//   tx_valid_o/tx_data_o/tx_chan_o/tx_last_o/tx_ready_i  output stream
//   tx_par_o                 even parity of tx_data_o (PORTGROUP_TXN_PARITY_EN only)
//
// Build option
//   PORTGROUP_TXN_PARITY_EN  adds the tx_par_o output and its parity register.
// -----------------------------------------------------------------------------
module portgroup_txn #(
  parameter int width_p = 8,
  parameter int chcnt_p = 4,
  parameter int gap_p   = 0
) (
  input  logic                                          main_clk_i,
  input  logic                                          main_rst_an_i,
  input  logic                                          regf_ctrl_ena_rval_i,
  input  logic [chcnt_p-1:0]                            regf_ctrl_chmask_rval_i,
  input  logic [chcnt_p*width_p-1:0]                    regf_tx_data_rval_i,
  input  logic                                          regf_tx_start_wr_i,
  output logic                                          regf_tx_busy_o,
  output logic                                          regf_tx_done_o,
  output logic [15:0]                                   regf_tx_cnt_o,
  output logic                                          tx_valid_o,
  output logic [width_p-1:0]                            tx_data_o,
  output logic [((chcnt_p > 1) ? $clog2(chcnt_p) : 1)-1:0] tx_chan_o,
  output logic                                          tx_last_o,
`ifdef PORTGROUP_TXN_PARITY_EN
  output logic                                          tx_par_o,
`endif
  input  logic                                          tx_ready_i
);

  localparam int chan_w = (chcnt_p > 1) ? $clog2(chcnt_p) : 1;
  localparam logic [7:0] gap_init = 8'(gap_p);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t                      state;
  state_t                      next_state;
  logic [chcnt_p-1:0]          shadow_mask;
  logic [chcnt_p-1:0]          next_mask;
  logic [chcnt_p-1:0]          rem_mask;
  logic [chcnt_p*width_p-1:0]  shadow_data;
  logic                        capture;
  logic [7:0]                  gap_cnt;
  logic [7:0]                  next_gap;
  logic                        next_valid;
  logic [width_p-1:0]          next_data;
  logic [chan_w-1:0]           next_chan;
  logic                        next_last;
  logic                        next_done;
  logic [15:0]                 next_cnt;
  logic [chan_w-1:0]           low_in;
  logic [chan_w-1:0]           low_rem;
  logic [chan_w-1:0]           low_shadow;

  // Index of the lowest set bit of a channel mask (0 for an empty mask).
  function automatic logic [chan_w-1:0] lowest_chan(input logic [chcnt_p-1:0] m);
    logic [chan_w-1:0] idx;
    idx = '0;
    for (int i = chcnt_p - 1; i >= 0; i--) begin
      if (m[i]) begin
        idx = chan_w'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  // True when exactly one channel bit is set.
  function automatic logic single_bit(input logic [chcnt_p-1:0] m);
    int n;
    n = 0;
    for (int i = 0; i < chcnt_p; i++) begin
      n = n + int'(m[i]);
    end
    return (n == 1);
  endfunction

  // Mask with the given channel's bit cleared.
  function automatic logic [chcnt_p-1:0] clear_chan(input logic [chcnt_p-1:0] m,
                                                    input logic [chan_w-1:0]  idx);
    logic [chcnt_p-1:0] r;
    for (int i = 0; i < chcnt_p; i++) begin
      r[i] = m[i] & (chan_w'(i) != idx);
    end
    return r;
  endfunction

  // Word of channel idx out of a packed channel vector.
  function automatic logic [width_p-1:0] word_at(input logic [chcnt_p*width_p-1:0] d,
                                                 input logic [chan_w-1:0]           idx);
    return d[int'(idx)*width_p +: width_p];
  endfunction

`ifdef PORTGROUP_TXN_PARITY_EN
  // Even parity of a data word.
  function automatic logic data_parity(input logic [width_p-1:0] w);
    return ^w;
  endfunction
`endif

  assign rem_mask   = clear_chan(shadow_mask, tx_chan_o);
  assign low_in     = lowest_chan(regf_ctrl_chmask_rval_i);
  assign low_rem    = lowest_chan(rem_mask);
  assign low_shadow = lowest_chan(shadow_mask);

  // Next-state and next-output decode; outputs are registered from these.
  always_comb begin
    next_state = state;
    next_mask  = shadow_mask;
    next_gap   = gap_cnt;
    next_valid = tx_valid_o;
    next_data  = tx_data_o;
    next_chan  = tx_chan_o;
    next_last  = tx_last_o;
    next_done  = 1'b0;
    next_cnt   = regf_tx_cnt_o;
    capture    = 1'b0;
    case (state)
      IDLE: begin
        if (regf_tx_start_wr_i && regf_ctrl_ena_rval_i &&
            (regf_ctrl_chmask_rval_i != '0)) begin
          // First word comes straight from the register inputs being captured.
          capture    = 1'b1;
          next_state = SEND;
          next_mask  = regf_ctrl_chmask_rval_i;
          next_valid = 1'b1;
          next_chan  = low_in;
          next_data  = word_at(regf_tx_data_rval_i, low_in);
          next_last  = single_bit(regf_ctrl_chmask_rval_i);
        end else begin
          next_valid = 1'b0;
          next_data  = '0;
          next_chan  = '0;
          next_last  = 1'b0;
        end
      end
      SEND: begin
        if (tx_ready_i) begin
          if (rem_mask == '0) begin
            next_state = IDLE;
            next_mask  = '0;
            next_valid = 1'b0;
            next_data  = '0;
            next_chan  = '0;
            next_last  = 1'b0;
            next_done  = 1'b1;
            next_cnt   = regf_tx_cnt_o + 16'd1;
          end else if (!regf_ctrl_ena_rval_i) begin
            // Abort: the word just accepted is the last one sent.
            next_state = IDLE;
            next_mask  = '0;
            next_valid = 1'b0;
            next_data  = '0;
            next_chan  = '0;
            next_last  = 1'b0;
          end else if (gap_p == 0) begin
            next_mask  = rem_mask;
            next_chan  = low_rem;
            next_data  = word_at(shadow_data, low_rem);
            next_last  = single_bit(rem_mask);
          end else begin
            next_state = GAP;
            next_mask  = rem_mask;
            next_gap   = gap_init;
            next_valid = 1'b0;
            next_data  = '0;
            next_chan  = '0;
            next_last  = 1'b0;
          end
        end else begin
          // Backpressure: hold the presented word.
          next_state = SEND;
        end
      end
      GAP: begin
        if (!regf_ctrl_ena_rval_i) begin
          next_state = IDLE;
          next_mask  = '0;
          next_gap   = 8'd0;
        end else if (gap_cnt == 8'd1) begin
          next_state = SEND;
          next_gap   = 8'd0;
          next_valid = 1'b1;
          next_chan  = low_shadow;
          next_data  = word_at(shadow_data, low_shadow);
          next_last  = single_bit(shadow_mask);
        end else begin
          next_gap   = gap_cnt - 8'd1;
        end
      end
      default: begin
        next_state = IDLE;
        next_mask  = '0;
        next_gap   = 8'd0;
        next_valid = 1'b0;
        next_data  = '0;
        next_chan  = '0;
        next_last  = 1'b0;
      end
    endcase
  end

  // State, shadow and output registers.
  always_ff @(posedge main_clk_i) begin
    if (!main_rst_an_i) begin
      state          <= IDLE;
      shadow_mask    <= '0;
      shadow_data    <= '0;
      gap_cnt        <= 8'd0;
      tx_valid_o     <= 1'b0;
      tx_data_o      <= '0;
      tx_chan_o      <= '0;
      tx_last_o      <= 1'b0;
      regf_tx_busy_o <= 1'b0;
      regf_tx_done_o <= 1'b0;
      regf_tx_cnt_o  <= 16'd0;
`ifdef PORTGROUP_TXN_PARITY_EN
      tx_par_o       <= 1'b0;
`endif
    end else begin
      state          <= next_state;
      shadow_mask    <= next_mask;
      shadow_data    <= capture ? regf_tx_data_rval_i : shadow_data;
      gap_cnt        <= next_gap;
      tx_valid_o     <= next_valid;
      tx_data_o      <= next_data;
      tx_chan_o      <= next_chan;
      tx_last_o      <= next_last;
      regf_tx_busy_o <= (next_state != IDLE);
      regf_tx_done_o <= next_done;
      regf_tx_cnt_o  <= next_cnt;
`ifdef PORTGROUP_TXN_PARITY_EN
      // next_data is zero whenever the stream is idle, so parity is 0 then.
      tx_par_o       <= data_parity(next_data);
`endif
    end
  end

endmodule

// File: tb/tb_portgroup_txn.sv
// -----------------------------------------------------------------------------
// tb_portgroup_txn
//   Scoreboard bench for portgroup_txn. Expected words are queued when a frame
//   is started and compared when the DUT hands them over. A second instance
//   with gap_p=2 exercises the inter-word gap.
// -----------------------------------------------------------------------------
module tb_portgroup_txn;

  typedef struct packed {
    logic [7:0] d;
    logic [1:0] c;
    logic       l;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ena;
  logic [3:0]  mask;
  logic [31:0] data;
  logic        start;
  logic        ready;
  logic        busy, done, valid, last, par;
  logic [15:0] cnt;
  logic [7:0]  tdata;
  logic [1:0]  chan;

  logic        start_g;
  logic        ready_g;
  logic        busy_g, done_g, valid_g, last_g, par_g;
  logic [15:0] cnt_g;
  logic [7:0]  tdata_g;
  logic [1:0]  chan_g;

  exp_t q[$];
  exp_t qg[$];
  int   hs0[$];
  int   hsg[$];
  int   cyc = 0;
  int   done_cnt = 0;
  int   last_done_cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   base_done;

  always #5 clk = ~clk;

  portgroup_txn #(.width_p(8), .chcnt_p(4), .gap_p(0)) dut (
    .main_clk_i(clk), .main_rst_an_i(rst_n),
    .regf_ctrl_ena_rval_i(ena), .regf_ctrl_chmask_rval_i(mask),
    .regf_tx_data_rval_i(data), .regf_tx_start_wr_i(start),
    .regf_tx_busy_o(busy), .regf_tx_done_o(done), .regf_tx_cnt_o(cnt),
    .tx_valid_o(valid), .tx_data_o(tdata), .tx_chan_o(chan), .tx_last_o(last),
`ifdef PORTGROUP_TXN_PARITY_EN
    .tx_par_o(par),
`endif
    .tx_ready_i(ready)
  );

  portgroup_txn #(.width_p(8), .chcnt_p(4), .gap_p(2)) dut_gap (
    .main_clk_i(clk), .main_rst_an_i(rst_n),
    .regf_ctrl_ena_rval_i(ena), .regf_ctrl_chmask_rval_i(mask),
    .regf_tx_data_rval_i(data), .regf_tx_start_wr_i(start_g),
    .regf_tx_busy_o(busy_g), .regf_tx_done_o(done_g), .regf_tx_cnt_o(cnt_g),
    .tx_valid_o(valid_g), .tx_data_o(tdata_g), .tx_chan_o(chan_g), .tx_last_o(last_g),
`ifdef PORTGROUP_TXN_PARITY_EN
    .tx_par_o(par_g),
`endif
    .tx_ready_i(ready_g)
  );

`ifndef PORTGROUP_TXN_PARITY_EN
  assign par   = 1'b0;
  assign par_g = 1'b0;
`endif

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 50 && q.size() != 0; i++) tick();
    check_eq("drain_timeout", q.size(), 0);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard for the gap_p=0 instance, plus done-pulse accounting.
  always @(negedge clk) begin
    exp_t e;
    if (done) begin
      done_cnt      <= done_cnt + 1;
      last_done_cyc <= cyc;
    end
    if (rst_n && valid && ready) begin
      hs0.push_back(cyc);
      if (q.size() == 0) begin
        check_eq("unexpected_word", 1, 0);
      end else begin
        e = q.pop_front();
        check_eq("word_data", tdata, e.d);
        check_eq("word_chan", chan, e.c);
        check_eq("word_last", last, e.l);
      end
    end
  end

  // Scoreboard for the gap_p=2 instance.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && valid_g && ready_g) begin
      hsg.push_back(cyc);
      if (qg.size() == 0) begin
        check_eq("gap_unexpected_word", 1, 0);
      end else begin
        e = qg.pop_front();
        check_eq("gap_word_data", tdata_g, e.d);
        check_eq("gap_word_chan", chan_g, e.c);
        check_eq("gap_word_last", last_g, e.l);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    exp_t t3[3];
    t3[0] = '{d: 8'h11, c: 2'd0, l: 1'b0};
    t3[1] = '{d: 8'h22, c: 2'd1, l: 1'b0};
    t3[2] = '{d: 8'h44, c: 2'd3, l: 1'b1};

    rst_n = 1'b0; ena = 1'b0; mask = 4'h0; data = 32'h0;
    start = 1'b0; ready = 1'b1; start_g = 1'b0; ready_g = 1'b1;
    repeat (3) tick();
    check_eq("rst_valid", valid, 0);
    check_eq("rst_data", tdata, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_cnt", cnt, 0);
    rst_n = 1'b1;
    tick();

    // Frame 1: mask 1011, ready held high -> back-to-back words.
    ena = 1'b1; mask = 4'b1011; data = 32'h44332211;
    for (int i = 0; i < 3; i++) q.push_back(t3[i]);
    hs0.delete();
    base_done = done_cnt;
    start = 1'b1; tick(); start = 1'b0;
    check_eq("latency_valid", valid, 1);
    drain();
    repeat (2) tick();
    check_eq("f1_words", hs0.size(), 3);
    if (hs0.size() == 3) begin
      check_eq("f1_back_to_back", hs0[2] - hs0[0], 2);
      check_eq("f1_done_timing", last_done_cyc, hs0[2] + 1);
    end
    check_eq("f1_done_once", done_cnt - base_done, 1);
    check_eq("f1_cnt", cnt, 1);
    check_eq("f1_busy", busy, 0);

    // Frame 2: ready 0,0,1 per word; outputs must hold under backpressure.
    ready = 1'b0;
    base_done = done_cnt;
    for (int i = 0; i < 3; i++) q.push_back(t3[i]);
    start = 1'b1; tick(); start = 1'b0;
    for (int w = 0; w < 3; w++) begin
      for (int k = 0; k < 3; k++) begin
        check_eq("bp_data", tdata, t3[w].d);
        check_eq("bp_chan", chan, t3[w].c);
        check_eq("bp_last", last, t3[w].l);
        if (k == 2) ready = 1'b1;
        tick();
      end
      ready = 1'b0;
    end
    repeat (3) tick();
    check_eq("f2_queue_empty", q.size(), 0);
    check_eq("f2_done_once", done_cnt - base_done, 1);
    check_eq("f2_cnt", cnt, 2);

    // Abort: ena dropped while the first word waits for ready.
    mask = 4'b0111; ready = 1'b0;
    base_done = done_cnt;
    q.push_back('{d: 8'h11, c: 2'd0, l: 1'b0});
    start = 1'b1; tick(); start = 1'b0;
    ena = 1'b0; tick();
    check_eq("abort_hold_valid", valid, 1);
    ready = 1'b1; tick(); ready = 1'b0;
    check_eq("abort_valid", valid, 0);
    check_eq("abort_busy", busy, 0);
    ready = 1'b1; repeat (4) tick();
    check_eq("abort_queue_empty", q.size(), 0);
    check_eq("abort_no_done", done_cnt - base_done, 0);
    check_eq("abort_cnt", cnt, 2);
    ena = 1'b1;

    // Ignored starts: empty mask, then ena low.
    mask = 4'b0000; start = 1'b1; tick(); start = 1'b0;
    check_eq("ign_mask0_busy", busy, 0);
    check_eq("ign_mask0_valid", valid, 0);
    ena = 1'b0; mask = 4'b1011; start = 1'b1; tick(); start = 1'b0;
    check_eq("ign_ena0_busy", busy, 0);
    repeat (2) tick();
    check_eq("ign_cnt", cnt, 2);
    ena = 1'b1;

    // Start while busy, with register inputs changed mid-frame.
    mask = 4'b0001; data = 32'h44332211; ready = 1'b0;
    base_done = done_cnt;
    q.push_back('{d: 8'h11, c: 2'd0, l: 1'b1});
    start = 1'b1; tick(); start = 1'b0;
    data = 32'hAAAAAAAA; mask = 4'b1111;
    start = 1'b1; tick(); start = 1'b0;
    check_eq("busy_start_busy", busy, 1);
    ready = 1'b1;
    drain();
    repeat (3) tick();
    check_eq("busy_start_done", done_cnt - base_done, 1);
    check_eq("busy_start_cnt", cnt, 3);
    check_eq("busy_start_idle", valid, 0);

    // Gap instance: two idle cycles between ch0 and ch1.
    mask = 4'b0011; data = 32'h44332211;
    qg.push_back('{d: 8'h11, c: 2'd0, l: 1'b0});
    qg.push_back('{d: 8'h22, c: 2'd1, l: 1'b1});
    hsg.delete();
    start_g = 1'b1; tick(); start_g = 1'b0;
    for (int i = 0; i < 50 && qg.size() != 0; i++) tick();
    check_eq("gap_drain", qg.size(), 0);
    repeat (2) tick();
    check_eq("gap_words", hsg.size(), 2);
    if (hsg.size() == 2) check_eq("gap_spacing", hsg[1] - hsg[0], 3);
    check_eq("gap_cnt", cnt_g, 1);

    // Counter wrap from 0xFFFF.
    force dut.regf_tx_cnt_o = 16'hFFFF;
    tick();
    release dut.regf_tx_cnt_o;
    tick();
    check_eq("wrap_preload", cnt, 16'hFFFF);
    mask = 4'b0100; ready = 1'b1;
    q.push_back('{d: 8'h33, c: 2'd2, l: 1'b1});
    start = 1'b1; tick(); start = 1'b0;
    drain();
    repeat (2) tick();
    check_eq("wrap_cnt", cnt, 0);

    // Reset mid-frame.
    mask = 4'b1011; ready = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    check_eq("mid_busy", busy, 1);
    rst_n = 1'b0; tick();
    check_eq("mid_rst_valid", valid, 0);
    check_eq("mid_rst_data", tdata, 0);
    check_eq("mid_rst_chan", chan, 0);
    check_eq("mid_rst_last", last, 0);
    check_eq("mid_rst_busy", busy, 0);
    check_eq("mid_rst_done", done, 0);
    rst_n = 1'b1; tick();
    check_eq("mid_rst_idle", valid, 0);

`ifdef PORTGROUP_TXN_PARITY_EN
    // Parity: 0x07 has three ones -> parity 1.
    mask = 4'b0001; data = 32'h00000007; ready = 1'b0;
    q.push_back('{d: 8'h07, c: 2'd0, l: 1'b1});
    start = 1'b1; tick(); start = 1'b0;
    check_eq("parity", par, 1);
    ready = 1'b1;
    drain();
    tick();
    check_eq("parity_idle", par, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/portgroup_txn.md
Name: portgroup_txn

Overview:
- Parametrised successor to the single-word port-group transmitter.
- Core-side block fed by register-file read values (enable, per-channel TX data, channel mask) plus a start write strobe.
- On start, snapshots up to chcnt_p channel words and sends the enabled ones as one frame, lowest channel first, over a valid/ready stream.
- Optional inter-word gap; reports busy, done and a completed-frame count back to the regf.

Parameters:
- width_p, 8, data word width (>=1).
- chcnt_p, 4, number of TX channels (>=1).
- gap_p, 0, idle cycles inserted between consecutive words of a frame (0..255).

Ports:
- main_clk_i  input  1  clock.
- main_rst_an_i  input  1  synchronous reset, active-low.
- regf_ctrl_ena_rval_i  input  1  global transmit enable (core read value).
- regf_ctrl_chmask_rval_i  input  chcnt_p  channel enable mask (core read value).
- regf_tx_data_rval_i  input  chcnt_p*width_p  channel i word at bits [i*width_p +: width_p].
- regf_tx_start_wr_i  input  1  single-cycle start strobe.
- regf_tx_busy_o  output  1  frame in progress.
- regf_tx_done_o  output  1  one-cycle pulse when a frame completes.
- regf_tx_cnt_o  output  16  completed-frame counter.
- tx_valid_o  output  1  stream valid.
- tx_data_o  output  width_p  stream data.
- tx_chan_o  output  max(1,$clog2(chcnt_p))  channel index of current word.
- tx_last_o  output  1  current word is last of frame.
- tx_ready_i  input  1  stream ready.

Behaviour:
- All state updates on rising main_clk_i; the reset condition is main_rst_an_i=0 sampled at the edge.
- Reset values: FSM=IDLE; shadow mask=0; gap counter=0; tx_valid_o=0; tx_data_o=0; tx_chan_o=0; tx_last_o=0; regf_tx_busy_o=0; regf_tx_done_o=0; regf_tx_cnt_o=0.
- FSM states: IDLE, SEND, GAP.
- IDLE -> SEND:
  - Condition: start=1, ena=1 and chmask!=0.
  - Same edge: capture all data words and chmask into shadow registers.
  - tx_valid_o=1 the next cycle, carrying the lowest set shadow channel. Latency from start = 1 cycle.
- IDLE, start ignored: start with ena=0 or chmask=0 is ignored; no done pulse, no count change.
- SEND, ready=0: tx_valid_o, tx_data_o, tx_chan_o and tx_last_o are held stable.
- SEND, handshake (valid&ready): clear that channel's shadow bit, then:
  - no bits remain -> IDLE, regf_tx_done_o=1 for one cycle, counter +1 (wraps 0xFFFF->0).
  - bits remain, ena=0 -> abort: IDLE, shadow cleared, no done, no count.
  - bits remain, gap_p=0 -> next word presented the following cycle (back-to-back, no bubble).
  - bits remain, gap_p>0 -> GAP, counter=gap_p. tx_valid_o=0 in GAP.
- GAP:
  - Decrement each cycle; at counter=1 -> SEND (valid=1 next cycle). Exactly gap_p idle cycles between words.
  - ena=0 during GAP -> abort to IDLE immediately (no done).
- Deasserting ena in SEND never drops valid before its handshake.
- tx_last_o=1 iff the shadow mask has exactly one bit set while in SEND.
- regf_tx_busy_o=1 in SEND and GAP. Start while busy is ignored; register input changes while busy do not affect the frame.
- Start and the final handshake on the same cycle: start is ignored because the FSM is not IDLE at that edge.
- Reset mid-frame: return to reset values next edge; frame discarded; no done pulse.
- tx_data_o=0 and tx_chan_o=0 whenever tx_valid_o=0.

Optional Feature:
- Macro: PORTGROUP_TXN_PARITY_EN.
- Defined:
  - Extra output tx_par_o (1 bit) = XOR of tx_data_o, i.e. even parity; 0 when tx_valid_o=0.
  - Registered alongside the data and held stable under backpressure.
- Not defined: port tx_par_o absent; no parity logic.

Test Plan:
- width_p=8, chcnt_p=4, gap_p=0, ena=1, mask=4'b1011, data={0x44,0x33,0x22,0x11}, start, ready=1 -> words 0x11/ch0, 0x22/ch1, 0x44/ch3 on three consecutive cycles; last only on 0x44; done pulse one cycle after; cnt=1, busy=0.
- Same frame, ready toggling 0,0,1 per word -> data/chan/last stable while ready=0; three words delivered; done once.
- gap_p=2, mask=4'b0011 -> exactly 2 cycles with valid=0 between ch0 and ch1 words.
- ena dropped during the first word with ready=0, then ready=1 -> first word completes; abort to IDLE; no further words; no done; cnt unchanged.
- Start with mask=0, start with ena=0, and start while busy -> each ignored; busy and cnt unaffected.
- Preload cnt to 0xFFFF via 65535 one-word frames (or forced), one more frame -> cnt=0. Assert reset mid-frame -> all outputs 0 next cycle. With PORTGROUP_TXN_PARITY_EN: data 0x07 -> tx_par_o=1.
